// File: rtl/read_arbiter_2to1.sv
// read_arbiter_2to1: round-robin arbiter sharing one AXI read slave between
// two requesters, one burst outstanding. Ports: s_* requesters, m_* slave.
module read_arbiter_2to1 #(
    parameter int C_AXI_ID_WIDTH   = 6,
    parameter int C_AXI_ADDR_WIDTH = 64,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_LEN_WIDTH  = 8,
    localparam int ARW = C_AXI_ID_WIDTH + C_AXI_ADDR_WIDTH
                       + C_AXI_LEN_WIDTH + 3 + 2,
    localparam int RW  = C_AXI_ID_WIDTH + C_AXI_DATA_WIDTH + 2 + 1
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic [1:0]       s_arvalid,
    output logic [1:0]       s_arready,
    input  logic [2*ARW-1:0] s_ar,
    output logic [1:0]       s_rvalid,
    input  logic [1:0]       s_rready,
    output logic [RW-1:0]    s_r,
    output logic             m_arvalid,
    input  logic             m_arready,
    output logic [ARW-1:0]   m_ar,
    input  logic             m_rvalid,
    output logic             m_rready,
    input  logic [RW-1:0]    m_r,
    output logic             busy,
    output logic             owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [ARW-1:0]   ar_q;
    logic             owner_q;
    logic             last_winner_q;
    logic             gnt;
    logic             take;

    // On a tie the requester that did not win last time goes next.
    assign gnt  = (&s_arvalid) ? ~last_winner_q : s_arvalid[1];
    assign take = (state_q == IDLE) && (|s_arvalid);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (|s_arvalid) state_d = ADDR;
            ADDR: if (m_arready) state_d = DATA;
            DATA: begin
                if (m_rvalid && s_rready[owner_q] && m_r[0]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ar_q          <= '0;
            owner_q       <= 1'b0;
            last_winner_q <= 1'b1;
        end else if (take) begin
            ar_q          <= gnt ? s_ar[2*ARW-1:ARW] : s_ar[ARW-1:0];
            owner_q       <= gnt;
            last_winner_q <= gnt;
        end
    end

    // Grant is combinational, so it is also masked by reset to keep
    // s_arready low while ARESETn is asserted.
    always_comb begin
        s_arready = 2'b00;
        s_rvalid  = 2'b00;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((|s_arvalid) && ARESETn) s_arready[gnt] = 1'b1;
            end
            ADDR: m_arvalid = 1'b1;
            DATA: begin
                s_rvalid[owner_q] = m_rvalid;
                m_rready          = s_rready[owner_q];
            end
            default: ;
        endcase
    end

    assign m_ar  = ar_q;
    assign s_r   = m_r;
    assign busy  = (state_q != IDLE);
    assign owner = owner_q;

endmodule

// File: tb/tb_read_arbiter_2to1.sv
// tb_read_arbiter_2to1: directed self-checking bench for read_arbiter_2to1.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_read_arbiter_2to1;

    localparam int IDW = 6;
    localparam int AW  = 64;
    localparam int DW  = 32;
    localparam int LW  = 8;
    localparam int ARW = IDW + AW + LW + 3 + 2;
    localparam int RW  = IDW + DW + 2 + 1;

    logic             clk;
    logic             rst_n;
    logic [1:0]       s_arvalid;
    logic [1:0]       s_arready;
    logic [2*ARW-1:0] s_ar;
    logic [1:0]       s_rvalid;
    logic [1:0]       s_rready;
    logic [RW-1:0]    s_r;
    logic             m_arvalid;
    logic             m_arready;
    logic [ARW-1:0]   m_ar;
    logic             m_rvalid;
    logic             m_rready;
    logic [RW-1:0]    m_r;
    logic             busy;
    logic             owner;

    int n_checks = 0;
    int n_fail   = 0;

    read_arbiter_2to1 dut (
        .ACLK      (clk),
        .ARESETn   (rst_n),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_ar      (s_ar),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_r       (s_r),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_ar      (m_ar),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_r       (m_r),
        .busy      (busy),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [ARW-1:0] mk_ar(
        input logic [IDW-1:0] id, input logic [AW-1:0] addr,
        input logic [LW-1:0] len);
        return {id, addr, len, 3'd2, 2'b01};
    endfunction

    function automatic logic [RW-1:0] mk_r(
        input logic [IDW-1:0] id, input logic [DW-1:0] data,
        input logic last);
        return {id, data, 2'b00, last};
    endfunction

    task automatic idle_inputs();
        s_arvalid = 2'b00;
        s_ar      = '0;
        s_rready  = 2'b11;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_r       = '0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        s_arvalid = 2'b11;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (s_arready !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_arready: got %b want 00", s_arready);
        end
        n_checks++;
        if ({m_arvalid, m_rready, s_rvalid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_valids: got %b want 0000",
                     {m_arvalid, m_rready, s_rvalid});
        end
        n_checks++;
        if ({busy, owner} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_busy_owner: got %b want 00", {busy, owner});
        end
        s_arvalid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [ARW-1:0] a0;
        logic [RW-1:0]  r;
        a0 = mk_ar(6'h05, 64'h0000_1000_0000_0040, 8'd3);
        s_arvalid = 2'b01;
        s_ar      = {mk_ar(6'h3f, 64'hdead, 8'd0), a0};
        m_arready = 1'b1;
        #1;
        n_checks++;
        if ({s_arready, m_arvalid, busy} !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_grant: got %b want 0100",
                     {s_arready, m_arvalid, busy});
        end
        @(negedge clk);
        s_arvalid = 2'b00;
        s_ar      = '0;
        #1;
        n_checks++;
        if ({m_arvalid, s_arready, busy, owner} !== 5'b10010) begin
            n_fail++;
            $display("FAIL single_addr: got %b want 10010",
                     {m_arvalid, s_arready, busy, owner});
        end
        n_checks++;
        if (m_ar !== a0) begin
            n_fail++;
            $display("FAIL single_m_ar: got %h want %h", m_ar, a0);
        end
        @(negedge clk);
        m_arready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            r = mk_r(6'h05, 32'ha000_0000 + k, k == 3);
            m_rvalid = 1'b1;
            m_r      = r;
            #1;
            n_checks++;
            if ({s_rvalid, m_rready, busy, m_arvalid} !== 5'b01110) begin
                n_fail++;
                $display("FAIL single_beat%0d: got %b want 01110", k,
                         {s_rvalid, m_rready, busy, m_arvalid});
            end
            n_checks++;
            if (s_r !== r) begin
                n_fail++;
                $display("FAIL single_s_r%0d: got %h want %h", k, s_r, r);
            end
            @(negedge clk);
        end
        m_rvalid = 1'b0;
        #1;
        n_checks++;
        if ({busy, s_rvalid, m_rready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_done: got %b want 0000",
                     {busy, s_rvalid, m_rready});
        end
    endtask

    task automatic test_round_robin();
        logic [ARW-1:0] p0;
        logic [ARW-1:0] p1;
        logic           e;
        pulse_reset();
        p0 = mk_ar(6'h01, 64'h100, 8'd0);
        p1 = mk_ar(6'h02, 64'h200, 8'd0);
        for (int k = 0; k < 4; k++) begin
            e = k[0];
            s_arvalid = 2'b11;
            s_ar      = {p1, p0};
            m_arready = 1'b1;
            #1;
            n_checks++;
            if (s_arready !== (e ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got %b want %b", k, s_arready,
                         e ? 2'b10 : 2'b01);
            end
            @(negedge clk);
            #1;
            n_checks++;
            if ({owner, s_arready, m_ar} !== {e, 2'b00, (e ? p1 : p0)}) begin
                n_fail++;
                $display("FAIL rr_addr%0d: got owner %b m_ar %h want %b %h",
                         k, owner, m_ar, e, e ? p1 : p0);
            end
            @(negedge clk);
            m_rvalid = 1'b1;
            m_r      = mk_r(6'h01, 32'h1234 + k, 1'b1);
            #1;
            n_checks++;
            if (s_rvalid !== (e ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL rr_rvalid%0d: got %b want %b", k, s_rvalid,
                         e ? 2'b10 : 2'b01);
            end
            @(negedge clk);
            m_rvalid = 1'b0;
        end
        idle_inputs();
    endtask

    task automatic test_ar_stall();
        logic [ARW-1:0] c1;
        c1 = mk_ar(6'h2a, 64'hfeed_beef_0000_1230, 8'd0);
        s_arvalid = 2'b10;
        s_ar      = {c1, mk_ar(6'h00, 64'h0, 8'd0)};
        m_arready = 1'b0;
        #1;
        n_checks++;
        if (s_arready !== 2'b10) begin
            n_fail++;
            $display("FAIL stall_grant: got %b want 10", s_arready);
        end
        @(negedge clk);
        s_arvalid = 2'b01;
        s_ar      = {2*ARW{1'b1}};
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if ({m_arvalid, s_arready, m_ar} !== {1'b1, 2'b00, c1}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got %b %b %h want 1 00 %h", k,
                         m_arvalid, s_arready, m_ar, c1);
            end
            @(negedge clk);
        end
        s_arvalid = 2'b00;
        m_arready = 1'b1;
        @(negedge clk);
        m_arready = 1'b0;
    endtask

    task automatic test_rready_stall();
        logic [RW-1:0] r;
        r = mk_r(6'h2a, 32'hcafe_f00d, 1'b1);
        m_rvalid = 1'b1;
        m_r      = r;
        s_rready = 2'b01;
        #1;
        n_checks++;
        if ({m_rready, s_rvalid, owner} !== 4'b0101) begin
            n_fail++;
            $display("FAIL rstall_block: got %b want 0101",
                     {m_rready, s_rvalid, owner});
        end
        @(negedge clk);
        s_rready = 2'b10;
        #1;
        n_checks++;
        if ({busy, m_rready, s_rvalid, s_r} !== {2'b11, 2'b10, r}) begin
            n_fail++;
            $display("FAIL rstall_release: got %b %b %b %h want 1 1 10 %h",
                     busy, m_rready, s_rvalid, s_r, r);
        end
        @(negedge clk);
        m_rvalid = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstall_done: got %b want 0", busy);
        end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        logic [ARW-1:0] b1;
        b1 = mk_ar(6'h11, 64'h8000, 8'd0);
        s_arvalid = 2'b01;
        s_ar      = {mk_ar(6'h0, 64'h0, 8'd0), mk_ar(6'h07, 64'h40, 8'd3)};
        m_arready = 1'b1;
        @(negedge clk);
        s_arvalid = 2'b00;
        @(negedge clk);
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        m_r       = mk_r(6'h07, 32'h1, 1'b0);
        @(negedge clk);
        m_r = mk_r(6'h07, 32'h2, 1'b0);
        #1;
        n_checks++;
        if ({busy, s_rvalid} !== 3'b101) begin
            n_fail++;
            $display("FAIL mreset_pre: got %b want 101", {busy, s_rvalid});
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({m_arvalid, m_rready, s_arready, s_rvalid, busy, owner}
            !== 8'h00) begin
            n_fail++;
            $display("FAIL mreset_outputs: got %b want 00000000",
                     {m_arvalid, m_rready, s_arready, s_rvalid, busy, owner});
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        s_arvalid = 2'b10;
        s_ar      = {b1, mk_ar(6'h0, 64'h0, 8'd0)};
        m_arready = 1'b1;
        #1;
        n_checks++;
        if (s_arready !== 2'b10) begin
            n_fail++;
            $display("FAIL mreset_grant: got %b want 10", s_arready);
        end
        @(negedge clk);
        s_arvalid = 2'b00;
        #1;
        n_checks++;
        if ({m_arvalid, owner, m_ar} !== {2'b11, b1}) begin
            n_fail++;
            $display("FAIL mreset_addr: got %b %b %h want 1 1 %h",
                     m_arvalid, owner, m_ar, b1);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_ar_stall();
        test_rready_stall();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
